// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debounce bank.
package key_pkg;

    localparam int   KEY_N_DEF      = 4;
    localparam int   KEY_SYNC_DEF   = 2;
    localparam int   KEY_STABLE_DEF = 50000;
    localparam logic KEY_RST_LVL    = 1'b0;

    // Smallest counter width whose range covers 0..stable-1.
    function automatic int key_min_cnt_w(input int stable);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(stable)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, stability counter, clean level and edge pulses.
// The fall pulse exists only when KEY_RELEASE_PULSE_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int SYNC_STAGES = KEY_SYNC_DEF,
    parameter int STABLE      = KEY_STABLE_DEF,
    parameter int CNT_W       = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_rise;
`ifdef KEY_RELEASE_PULSE_EN
    logic                   r_fall;
`endif
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // (r_q, r_cnt) is the channel state: r_cnt==0 with w_s==r_q is idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{KEY_RST_LVL}};
            r_cnt  <= '0;
            r_q    <= KEY_RST_LVL;
            r_rise <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            r_fall <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_rise <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            r_fall <= 1'b0;
`endif
            if (w_s == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_q    <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
`ifdef KEY_RELEASE_PULSE_EN
                r_fall <= ~w_s;
`endif
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_rise;
`ifdef KEY_RELEASE_PULSE_EN
    assign o_fall = r_fall;
`else
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N independent debounced key channels with Q/notQ and rise/fall pulses.
// Optional KEY_RELEASE_PULSE_EN enables the fall pulses; otherwise fall is all 0.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int N           = KEY_N_DEF,
    parameter int SYNC_STAGES = KEY_SYNC_DEF,
    parameter int STABLE      = KEY_STABLE_DEF,
    parameter int CNT_W       = 16
) (
    input  logic         C,
    input  logic         rst_n,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic [N-1:0] notQ,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    if (N < 1 || N > 16) begin : g_bad_n
        $error("key_debounce_bank: N=%0d outside 1..16", N);
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("key_debounce_bank: SYNC_STAGES=%0d outside 2..3", SYNC_STAGES);
    end
    if (STABLE < 1) begin : g_bad_stable
        $error("key_debounce_bank: STABLE must be >= 1");
    end
    if (CNT_W < key_min_cnt_w(STABLE)) begin : g_bad_cnt_w
        $error("key_debounce_bank: CNT_W=%0d too small for STABLE=%0d", CNT_W, STABLE);
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        key_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE      (STABLE),
            .CNT_W       (CNT_W)
        ) u_ch (
            .i_clk   (C),
            .i_rst_n (rst_n),
            .i_d     (D[g]),
            .o_q     (Q[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g])
        );
    end

    assign notQ = ~Q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank with N=4, SYNC_STAGES=2, STABLE=4, CNT_W=3.
module tb_key_debounce_bank;

    localparam int N = 4;

    logic         C;
    logic         rst_n;
    logic [N-1:0] D;
    logic [N-1:0] Q;
    logic [N-1:0] notQ;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    logic         clk_en;
    logic [N-1:0] fall_seen;
    logic [N-1:0] q_seen;
    logic [N-1:0] rise_seen;
    int           n_cmp;
    int           n_bad;

`ifdef KEY_RELEASE_PULSE_EN
    localparam bit FALL_ON = 1'b1;
`else
    localparam bit FALL_ON = 1'b0;
`endif

    key_debounce_bank #(
        .N           (N),
        .SYNC_STAGES (2),
        .STABLE      (4),
        .CNT_W       (3)
    ) dut (
        .C     (C),
        .rst_n (rst_n),
        .D     (D),
        .Q     (Q),
        .notQ  (notQ),
        .rise  (rise),
        .fall  (fall)
    );

    initial C = 1'b0;
    always begin
        #5;
        if (clk_en) C = ~C;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge C);
        #1;
        fall_seen |= fall;
        q_seen    |= Q;
        rise_seen |= rise;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        fall_seen = '0;
        q_seen    = '0;
        rise_seen = '0;
        clk_en    = 1'b0;
        rst_n     = 1'b0;
        D         = 4'b1111;

        // Reset values with no clock running
        #3;
        chk_eq("rst_q",    32'(Q),    32'h0);
        chk_eq("rst_notq", 32'(notQ), 32'hF);
        chk_eq("rst_rise", 32'(rise), 32'h0);
        chk_eq("rst_fall", 32'(fall), 32'h0);

        clk_en = 1'b1;
        run(3);
        chk_eq("rst_clk_q", 32'(Q), 32'h0);
        D     = 4'b0000;
        rst_n = 1'b1;
        run(4);

        // Accepted press on channel 0: accept on the 6th edge
        D = 4'b0001;
        run(5);
        chk_eq("press_e5_q",    32'(Q),    32'h0);
        chk_eq("press_e5_rise", 32'(rise), 32'h0);
        step();
        chk_eq("press_e6_q",    32'(Q),    32'h1);
        chk_eq("press_e6_rise", 32'(rise), 32'h1);
        chk_eq("press_e6_notq", 32'(notQ), 32'hE);
        step();
        chk_eq("press_e7_rise", 32'(rise), 32'h0);
        chk_eq("press_e7_q",    32'(Q),    32'h1);

        // Glitch on channel 1: high for 3 sampled edges only
        q_seen    = '0;
        rise_seen = '0;
        D = 4'b0011;
        run(3);
        D = 4'b0001;
        run(10);
        chk_eq("glitch_q1",    32'(q_seen[1]),    32'h0);
        chk_eq("glitch_rise1", 32'(rise_seen[1]), 32'h0);

        // Channel 1 high for exactly 4 sampled edges: accepted, then released
        D = 4'b0011;
        run(4);
        D = 4'b0001;
        step();
        chk_eq("pulse4_e5_q", 32'(Q), 32'h1);
        step();
        chk_eq("pulse4_e6_q",    32'(Q),    32'h3);
        chk_eq("pulse4_e6_rise", 32'(rise), 32'h2);
        run(3);
        chk_eq("pulse4_e9_q",   32'(Q), 32'h3);
        step();
        chk_eq("pulse4_e10_q",    32'(Q),    32'h1);
        chk_eq("pulse4_e10_fall", 32'(fall), FALL_ON ? 32'h2 : 32'h0);

        // Release on channel 2
        D = 4'b0101;
        run(6);
        chk_eq("rel_setup_q", 32'(Q), 32'h5);
        D = 4'b0001;
        run(5);
        chk_eq("rel_e5_q",    32'(Q),    32'h5);
        chk_eq("rel_e5_fall", 32'(fall), 32'h0);
        step();
        chk_eq("rel_e6_q",    32'(Q),    32'h1);
        chk_eq("rel_e6_fall", 32'(fall), FALL_ON ? 32'h4 : 32'h0);
        chk_eq("rel_e6_rise", 32'(rise), 32'h0);
        step();
        chk_eq("rel_e7_fall", 32'(fall), 32'h0);

        // Simultaneous channels 1 and 3 rise while channel 0 releases
        D = 4'b1010;
        run(5);
        chk_eq("simul_e5_q", 32'(Q), 32'h1);
        step();
        chk_eq("simul_rise", 32'(rise), 32'hA);
        chk_eq("simul_q",    32'(Q),    32'hA);
        chk_eq("simul_notq", 32'(notQ), 32'h5);
        chk_eq("simul_fall", 32'(fall), FALL_ON ? 32'h1 : 32'h0);
        step();
        chk_eq("simul_e7_rise", 32'(rise), 32'h0);

        // Mid-count reset on channel 3
        D = 4'b0000;
        run(8);
        chk_eq("mid_setup_q", 32'(Q), 32'h0);
        D = 4'b1000;
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_q", 32'(Q), 32'h0);
        run(2);
        rst_n     = 1'b1;
        q_seen    = '0;
        rise_seen = '0;
        run(5);
        chk_eq("mid_e5_qseen",    32'(q_seen),    32'h0);
        chk_eq("mid_e5_riseseen", 32'(rise_seen), 32'h0);
        step();
        chk_eq("mid_e6_q",    32'(Q),    32'h8);
        chk_eq("mid_e6_rise", 32'(rise), 32'h8);

`ifndef KEY_RELEASE_PULSE_EN
        chk_eq("fall_never", 32'(fall_seen), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
